display_alarm_arbiter: RTL and testbench

Owns the 32-bit active-low seven-segment bus between the Nios PIO display word and a hardware alarm overlay. When the alarm fires, it takes over the display with a blinking alarm pattern, times out unattended alarms, and hands the bus back to the CPU on acknowledge or cancel. It sits between the platform's 7-segment PIO export and the board pins, in the single system clock domain.

---
 rtl/display_alarm_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_alarm_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/display_alarm_arbiter.sv
// Arbitrates the active-low 32-bit seven-segment bus between the CPU word and a blinking alarm overlay.
// Optional feature macro: DISPLAY_ALARM_SNOOZE_EN (ack snoozes and re-rings instead of releasing the bus).
module display_alarm_arbiter #(
  parameter int unsigned BLINK_DIV    = 12_500_000,
  parameter int unsigned RING_MAX     = 240,
  parameter int unsigned SNOOZE_TICKS = 1200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_seg,
  input  logic        cpu_we,
  input  logic        alarm_req,
  input  logic [31:0] alarm_seg,
  input  logic        ack_n,
  output logic [31:0] seg_out,
  output logic        ringing,
  output logic        snoozing,
  output logic        missed
);
  localparam int unsigned PW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned CMAX = (RING_MAX > SNOOZE_TICKS) ? RING_MAX : SNOOZE_TICKS;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_RING_ON  = 2'd1,
    S_RING_OFF = 2'd2
`ifdef DISPLAY_ALARM_SNOOZE_EN
    ,S_SNOOZE  = 2'd3
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_cpu_seg, w_cpu_seg_nxt;
  logic [31:0]     r_seg_out, w_seg_nxt;
  logic            r_req_d;
  logic [2:0]      r_ack_sync;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [CW-1:0]   r_ring_cnt, w_ring_nxt;
  logic            r_missed, w_missed_nxt;
  logic            w_req_rise, w_ack, w_tick, w_timeout;
  logic            w_ring_st, w_nxt_ring, w_snz_st, w_nxt_snz, w_keep;

  assign w_cpu_seg_nxt = cpu_we ? cpu_seg : r_cpu_seg;
  assign w_req_rise    = alarm_req & ~r_req_d;
  assign w_ack         = r_ack_sync[2] & ~r_ack_sync[1];
  assign w_ring_st     = (r_state == S_RING_ON) || (r_state == S_RING_OFF);
  assign w_nxt_ring    = (w_state_nxt == S_RING_ON) || (w_state_nxt == S_RING_OFF);
  assign w_tick        = (w_ring_st || w_snz_st) && (r_presc == PW'(BLINK_DIV - 1));
  assign w_timeout     = w_ring_st && w_tick && (r_ring_cnt == CW'(RING_MAX - 1));

`ifdef DISPLAY_ALARM_SNOOZE_EN
  logic [CW-1:0] r_snz_cnt, w_snz_nxt;
  logic          w_snz_done;

  assign w_snz_st   = (r_state == S_SNOOZE);
  assign w_nxt_snz  = (w_state_nxt == S_SNOOZE);
  assign w_snz_done = w_snz_st && w_tick && (r_snz_cnt == CW'(SNOOZE_TICKS - 1));
  assign w_snz_nxt  = (w_nxt_snz && w_snz_st) ? (w_tick ? r_snz_cnt + 1'b1 : r_snz_cnt) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_snz_cnt <= '0;
    else          r_snz_cnt <= w_snz_nxt;
  end
`else
  assign w_snz_st  = 1'b0;
  assign w_nxt_snz = 1'b0;
`endif

  // Priority within ringing: cancel > ack > timeout > blink tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_missed_nxt = r_missed;
    case (r_state)
      S_CPU: begin
        if (w_req_rise) begin
          w_state_nxt  = S_RING_ON;
          w_missed_nxt = 1'b0;
        end
      end
      S_RING_ON, S_RING_OFF: begin
        if (!alarm_req) begin
          w_state_nxt = S_CPU;
        end else if (w_ack) begin
`ifdef DISPLAY_ALARM_SNOOZE_EN
          w_state_nxt = S_SNOOZE;
`else
          w_state_nxt = S_CPU;
`endif
        end else if (w_timeout) begin
          w_state_nxt  = S_CPU;
          w_missed_nxt = 1'b1;
        end else if (w_tick) begin
          w_state_nxt = (r_state == S_RING_ON) ? S_RING_OFF : S_RING_ON;
        end
      end
`ifdef DISPLAY_ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (!alarm_req)      w_state_nxt = S_CPU;
        else if (w_snz_done) w_state_nxt = S_RING_ON;
      end
`endif
      default: w_state_nxt = S_CPU;
    endcase
  end

  // Counters keep running only while staying inside the same ring or snooze region; any entry restarts them.
  assign w_keep      = (w_nxt_ring && w_ring_st) || (w_nxt_snz && w_snz_st);
  assign w_presc_nxt = (w_keep && !w_tick) ? r_presc + 1'b1 : '0;
  assign w_ring_nxt  = (w_nxt_ring && w_ring_st) ? (w_tick ? r_ring_cnt + 1'b1 : r_ring_cnt) : '0;

  always_comb begin
    w_seg_nxt = w_cpu_seg_nxt;
    if (w_state_nxt == S_RING_ON)       w_seg_nxt = alarm_seg;
    else if (w_state_nxt == S_RING_OFF) w_seg_nxt = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CPU;
      r_cpu_seg  <= '1;
      r_seg_out  <= '1;
      r_req_d    <= 1'b1;
      r_ack_sync <= '1;
      r_presc    <= '0;
      r_ring_cnt <= '0;
      r_missed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_seg  <= w_cpu_seg_nxt;
      r_seg_out  <= w_seg_nxt;
      r_req_d    <= alarm_req;
      r_ack_sync <= {r_ack_sync[1:0], ack_n};
      r_presc    <= w_presc_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_missed   <= w_missed_nxt;
    end
  end

  assign seg_out  = r_seg_out;
  assign ringing  = w_ring_st;
  assign snoozing = w_snz_st;
  assign missed   = r_missed;
endmodule

// File: tb/tb_display_alarm_arbiter.sv
// Scoreboard bench for display_alarm_arbiter: stimulus queues expected outputs per cycle, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_display_alarm_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_seg = '0;
  logic        cpu_we = 1'b0;
  logic        alarm_req = 1'b0;
  logic [31:0] alarm_seg = '0;
  logic        ack_n = 1'b1;
  logic [31:0] seg_out;
  logic        ringing, snoozing, missed;

  display_alarm_arbiter #(.BLINK_DIV(4), .RING_MAX(6), .SNOOZE_TICKS(3)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_seg(cpu_seg), .cpu_we(cpu_we),
    .alarm_req(alarm_req), .alarm_seg(alarm_seg), .ack_n(ack_n),
    .seg_out(seg_out), .ringing(ringing), .snoozing(snoozing), .missed(missed)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned q_cyc[$];
  logic [34:0] q_val[$];
  string       q_nm[$];
  int          n_checks = 0;
  int          n_fail = 0;

  int unsigned m_cyc;
  logic [34:0] m_val;
  string       m_nm;

  task automatic expect_at(input int unsigned d, input logic [31:0] seg, input logic rg,
                           input logic sz, input logic ms, input string nm);
    q_cyc.push_back(cyc + d);
    q_val.push_back({seg, rg, sz, ms});
    q_nm.push_back(nm);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      m_cyc = q_cyc.pop_front();
      m_val = q_val.pop_front();
      m_nm  = q_nm.pop_front();
      n_checks++;
      if (m_cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", m_nm, m_cyc, cyc);
      end else if ({seg_out, ringing, snoozing, missed} !== m_val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got seg=%h ring=%b snz=%b miss=%b, want seg=%h ring=%b snz=%b miss=%b",
                 m_nm, cyc, seg_out, ringing, snoozing, missed,
                 m_val[34:3], m_val[2], m_val[1], m_val[0]);
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete by %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    expect_at(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "reset");
    expect_at(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "idle");
    tick(2);

    // CPU write
    cpu_seg = 32'h1234_5678;
    cpu_we  = 1'b1;
    expect_at(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "pre_write");
    expect_at(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "cpu_write");
    tick(1);
    cpu_we  = 1'b0;
    cpu_seg = 32'h0BAD_0BAD;
    expect_at(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "cpu_hold");
    tick(2);

    // Blink and timeout: six 4-cycle phases, then CPU word with missed set
    alarm_seg = 32'hC0C0_C0C0;
    alarm_req = 1'b1;
    expect_at(0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "pre_ring");
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 4; k++)
        expect_at(1 + 4 * p + k, (p % 2 == 0) ? 32'hC0C0_C0C0 : 32'hFFFF_FFFF,
                  1'b1, 1'b0, 1'b0, (p % 2 == 0) ? "blink_on" : "blink_off");
    expect_at(25, 32'h1234_5678, 1'b0, 1'b0, 1'b1, "timeout");
    tick(25);
    alarm_req = 1'b0;
    expect_at(1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, "missed_sticky");
    tick(2);

    // Acknowledge mid-RING_OFF; the new alarm start clears missed
    alarm_req = 1'b1;
    for (int d = 1; d <= 4; d++) expect_at(d, 32'hC0C0_C0C0, 1'b1, 1'b0, 1'b0, "ack_ring_on");
    for (int d = 5; d <= 7; d++) expect_at(d, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "ack_ring_off");
`ifdef DISPLAY_ALARM_SNOOZE_EN
    for (int d = 8; d <= 19; d++) expect_at(d, 32'h1234_5678, 1'b0, 1'b1, 1'b0, "snooze");
    expect_at(20, 32'hC0C0_C0C0, 1'b1, 1'b0, 1'b0, "re_ring");
`else
    expect_at(8, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "ack_to_cpu");
`endif
    tick(5);
    ack_n = 1'b0;
    tick(4);
    ack_n = 1'b1;
`ifdef DISPLAY_ALARM_SNOOZE_EN
    tick(11);
    alarm_req = 1'b0;
    expect_at(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "snooze_cancel");
`else
    alarm_req = 1'b0;
    expect_at(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "ack_idle");
`endif
    tick(2);

    // Cancel with a CPU write and a live alarm pattern change during the ring
    alarm_req = 1'b1;
    expect_at(1, 32'hC0C0_C0C0, 1'b1, 1'b0, 1'b0, "cancel_ring");
    tick(1);
    alarm_seg = 32'h3C3C_3C3C;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "live_alarm_seg");
    tick(1);
    cpu_seg = 32'hAAAA_5555;
    cpu_we  = 1'b1;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "ring_during_we");
    tick(1);
    cpu_we    = 1'b0;
    alarm_req = 1'b0;
    expect_at(1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, "cancel_cpu_word");
    tick(2);

    // Priority: ack and cancel in the same cycle
    alarm_req = 1'b1;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "pa_ring");
    tick(1);
    ack_n = 1'b0;
    tick(2);
    alarm_req = 1'b0;
    expect_at(1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, "pa_cancel_wins");
    tick(1);
    ack_n = 1'b1;
    tick(3);

    // Priority: ack on the same cycle as the timeout tick
    alarm_req = 1'b1;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "pb_ring");
    tick(22);
    expect_at(0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "pb_last_phase");
    ack_n = 1'b0;
    tick(3);
    ack_n = 1'b1;
`ifdef DISPLAY_ALARM_SNOOZE_EN
    expect_at(0, 32'hAAAA_5555, 1'b0, 1'b1, 1'b0, "pb_ack_beats_timeout");
`else
    expect_at(0, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, "pb_ack_beats_timeout");
`endif
    alarm_req = 1'b0;
    expect_at(1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, "pb_exit");
    tick(2);

    // Asynchronous reset mid-operation, with alarm_req held high through release
    alarm_req = 1'b1;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "rst_pre_ring");
`ifdef DISPLAY_ALARM_SNOOZE_EN
    tick(2);
    ack_n = 1'b0;
    tick(3);
    expect_at(0, 32'hAAAA_5555, 1'b0, 1'b1, 1'b0, "rst_pre_snooze");
    ack_n = 1'b1;
    tick(1);
`else
    tick(3);
`endif
    reset_n = 1'b0;
    expect_at(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "async_reset");
    tick(2);
    reset_n = 1'b1;
    expect_at(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "rst_release");
    expect_at(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "req_high_no_ring");
    expect_at(2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "req_high_no_ring2");
    tick(3);
    alarm_req = 1'b0;
    tick(1);
    alarm_req = 1'b1;
    expect_at(1, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, "rearm_ring");
    tick(2);
    alarm_req = 1'b0;
    expect_at(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "rearm_cancel");
    tick(3);

    while (q_cyc.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", q_nm[0], q_cyc[0]);
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_nm.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
